// File: rtl/control_fsm_pkg.sv
// control_fsm_pkg: shared state, opcode and ALU operation encodings
package control_fsm_pkg;
   typedef logic [2:0] state_t;
   localparam state_t S_FETCH  = 3'd0;
   localparam state_t S_DECODE = 3'd1;
   localparam state_t S_EXEC   = 3'd2;
   localparam state_t S_MEM    = 3'd3;
   localparam state_t S_WB     = 3'd4;
   localparam logic [2:0] OP_R   = 3'd0;
   localparam logic [2:0] OP_LW  = 3'd5;
   localparam logic [2:0] OP_SW  = 3'd6;
   localparam logic [2:0] OP_BEQ = 3'd7;
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_R   = 2'b10;
   localparam logic [1:0] ALU_IMM = 2'b11;
   function automatic logic is_imm(input logic [2:0] op);
      return op inside {[3'd1:3'd4]};
   endfunction
endpackage

// File: rtl/control_fsm_if.sv
// control_fsm_if: memory handshake, ALU flag and datapath control bundle
interface control_fsm_if;
   logic [15:0] instr;
   logic        mem_ready;
   logic        zero;
   logic [1:0]  alu_op;
   logic [2:0]  opcode;
   logic [2:0]  funct;
   logic        pc_write;
   logic        pc_src;
   logic        ir_write;
   logic        mem_read;
   logic        mem_write;
   logic        reg_write;
   logic        reg_dst;
   logic        alu_src;
   logic        mem_to_reg;
   logic [15:0] retire_count;
   modport master (
      input  instr, mem_ready, zero,
      output alu_op, opcode, funct, pc_write, pc_src, ir_write, mem_read,
             mem_write, reg_write, reg_dst, alu_src, mem_to_reg, retire_count
   );
   modport slave (
      output instr, mem_ready, zero,
      input  alu_op, opcode, funct, pc_write, pc_src, ir_write, mem_read,
             mem_write, reg_write, reg_dst, alu_src, mem_to_reg, retire_count
   );
endinterface

// File: rtl/control_fsm.sv
// control_fsm: multicycle fetch/decode/exec/mem/wb controller with retire counter
module control_fsm
   import control_fsm_pkg::*;
(
   input logic           clk,
   input logic           rst_n,
   control_fsm_if.master bus
);
   state_t      state, state_nxt;
   logic [2:0]  ir_op, ir_fn;
   logic [15:0] retire_cnt;
   logic        fetch, exec, mem, wb, fetch_done, retire;
   logic        r_type, lw, sw, beq;
   assign r_type     = ir_op == OP_R;
   assign lw         = ir_op == OP_LW;
   assign sw         = ir_op == OP_SW;
   assign beq        = ir_op == OP_BEQ;
   assign fetch      = rst_n && state == S_FETCH;
   assign exec       = state == S_EXEC;
   assign mem        = state == S_MEM;
   assign wb         = state == S_WB;
   assign fetch_done = fetch && bus.mem_ready;
   assign retire     = (exec && beq) || (mem && sw && bus.mem_ready) || wb;
   assign bus.mem_read     = fetch || (mem && lw);
   assign bus.mem_write    = mem && sw;
   assign bus.ir_write     = fetch_done;
   assign bus.pc_write     = fetch_done || (exec && beq && bus.zero);
   assign bus.pc_src       = exec && beq;
   assign bus.reg_write    = wb;
   assign bus.reg_dst      = wb && r_type;
   assign bus.mem_to_reg   = wb && lw;
   assign bus.alu_src      = (exec && !r_type && !beq) || mem;
   assign bus.alu_op       = !exec ? ALU_ADD : r_type ? ALU_R : beq ? ALU_SUB : is_imm(ir_op) ? ALU_IMM : ALU_ADD;
   assign bus.opcode       = ir_op;
   assign bus.funct        = ir_fn;
   assign bus.retire_count = retire_cnt;
   // next-state selection; memory states wait on the handshake
   always_comb begin
      state_nxt = S_FETCH;
      case (state)
         S_FETCH:  state_nxt = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: state_nxt = S_EXEC;
         S_EXEC:   state_nxt = beq ? S_FETCH : (lw || sw) ? S_MEM : S_WB;
         S_MEM:    state_nxt = !bus.mem_ready ? S_MEM : lw ? S_WB : S_FETCH;
         default:  state_nxt = S_FETCH;
      endcase
   end
   // state, held instruction fields and retire counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_FETCH;
         ir_op      <= '0;
         ir_fn      <= '0;
         retire_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (fetch_done) begin
            ir_op <= bus.instr[15:13];
            ir_fn <= bus.instr[2:0];
         end
         if (retire) retire_cnt <= retire_cnt + 16'd1;
      end
   end
endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Clock  in  1  single system clock; all state updates on rising edge.
REQ-002 ResetN  in  1  asynchronous, active-low reset.
REQ-003 Instr  in  16  memory read data; captured as instruction in FETCH.
REQ-004 MemReady  in  1  memory handshake; access completes in a cycle where MemReady=1.
REQ-005 Zero  in  1  ALU zero flag, sampled in EXEC for BEQ.
REQ-006 ALUOp  out  2  ALU operation class: 00 add (LW/SW), 01 subtract (BEQ), 10 R-type (use Funct), 11 immediate (use Opcode).
REQ-007 Opcode  out  3  held IR[15:13], fed to ALU control.
REQ-008 Funct  out  3  held IR[2:0], fed to ALU control.
REQ-009 PCWrite, PCSrc, IRWrite, MemRead, MemWrite, RegWrite, RegDst, ALUSrc, MemToReg  out  1 each  datapath strobes/selects.
REQ-010 RetireCount  out  16  count of completed instructions.

Function
REQ-011 Opcode map: 000 R-type; 001-100 immediate ALU; 101 LW; 110 SW; 111 BEQ.
REQ-012 States: FETCH, DECODE, EXEC, MEM, WB; one-hot control outputs are Moore functions of state and held IR, except PCWrite in EXEC (depends on Zero) and FETCH/MEM strobes (depend on MemReady).
REQ-013 FETCH: MemRead=1; while MemReady=0 remain, all other strobes 0; when MemReady=1 assert IRWrite=1, PCWrite=1, PCSrc=0, capture Instr into internal IR, next DECODE.
REQ-014 DECODE: all strobes 0; next EXEC; fixed one cycle.
REQ-015 EXEC: ALUOp per REQ-006; ALUSrc=1 for opcodes 001-110, 0 otherwise.
REQ-016 EXEC BEQ: PCSrc=1, PCWrite=Zero; next FETCH; counts as retired.
REQ-017 EXEC R-type/immediate: next WB; LW/SW: next MEM.
REQ-018 MEM: LW asserts MemRead, SW asserts MemWrite, held (ALUOp=00, ALUSrc=1) until MemReady=1; then SW next FETCH (retired), LW next WB.
REQ-019 WB: RegWrite=1 for exactly one cycle; RegDst=1 for R-type else 0; MemToReg=1 for LW else 0; next FETCH; retired.
REQ-020 Latencies with MemReady=1 always: R/immediate/LW-less = 4 cycles, LW 5, SW 4, BEQ 3.
REQ-021 RetireCount increments by 1 on the retire cycle's clock edge; wraps 0xFFFF -> 0x0000.
REQ-022 MemRead and MemWrite never asserted in the same cycle; RegWrite and MemWrite never together.
REQ-023 Opcode/Funct change only on IRWrite edges; stable through all later states of the instruction.

Reset
REQ-024 ResetN=0 forces state FETCH, IR=0, RetireCount=0 immediately, independent of Clock.
REQ-025 During reset all strobes 0 and ALUOp=00, Opcode=000, Funct=000.
REQ-026 Reset asserted mid-instruction (including a MEM stall) abandons it without retiring; first cycle after deassertion is FETCH with MemRead=1.

Structure
REQ-027 Shared package holds state enum (3-bit encoding), opcode constants, and ALUOp encodings; ALU control imports the same ALUOp constants.
REQ-028 Single module, no sub-modules; retire counter inline.

Verification
REQ-029 ADD R-type 0x0000-class instr (opcode 000, funct 000), MemReady=1 -> FETCH,DECODE,EXEC(ALUOp=10),WB(RegWrite=1,RegDst=1); RetireCount 0->1 after 4 cycles.
REQ-030 LW (opcode 101) with MemReady low 3 cycles in MEM -> MemRead held 4 cycles, WB MemToReg=1, total 8 cycles.
REQ-031 BEQ (opcode 111) with Zero=1 then Zero=0 -> EXEC PCWrite=1,PCSrc=1 first, PCWrite=0 second; ALUOp=01; no RegWrite.
REQ-032 SW (opcode 110) -> MemWrite one cycle, never RegWrite; next cycle FETCH.
REQ-033 Preload RetireCount to 0xFFFF via 65535 BEQs, retire one more -> 0x0000.
REQ-034 ResetN pulsed low mid-MEM stall -> outputs zero asynchronously, RetireCount=0, restart in FETCH.
